// File: rtl/arb_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: requester count,
// default hold limit and FSM state encoding.
package arb_pkg;

  localparam int unsigned NumReq         = 4;
  localparam int unsigned DefaultMaxHold = 8;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set bit of i_req scanning upward
// from i_start, wrapping 3->0.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NumReq-1:0] i_req,
  input  logic [1:0]        i_start,
  output logic [NumReq-1:0] o_gnt,
  output logic [1:0]        o_idx,
  output logic              o_found
);

  logic [1:0] w_cand;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NumReq; k++) begin
      w_cand = i_start + 2'(k);
      if (!o_found && i_req[w_cand]) begin
        o_found       = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with a hold-time limit: an owner that keeps
// its request for MAX_HOLD cycles is preempted when anyone else is waiting.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DefaultMaxHold,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NumReq-1:0] req,
  output logic [NumReq-1:0] gnt,
  output logic [1:0]        gnt_idx,
  output logic              busy,
  output logic              preempt
);

  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  arb_state_e        r_state;
  logic [NumReq-1:0] r_gnt;
  logic [1:0]        r_gnt_idx;
  logic              r_busy;
  logic              r_preempt;
  logic [CNT_W-1:0]  r_hold_cnt;
  logic [1:0]        r_last_idx;

  logic [NumReq-1:0] w_mask;
  logic [1:0]        w_start;
  logic [NumReq-1:0] w_pick_gnt;
  logic [1:0]        w_pick_idx;
  logic              w_found;
  logic              w_owner_req;
  logic              w_timeout;

  // Masking out the current owner lets one picker serve idle, release and preemption.
  assign w_mask      = req & ~r_gnt;
  assign w_start     = r_last_idx + 2'd1;
  assign w_owner_req = |(req & r_gnt);
  assign w_timeout   = (r_hold_cnt == HoldLast);

  rr_pick4 u_pick (
    .i_req   (w_mask),
    .i_start (w_start),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_found (w_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_gnt      <= '0;
      r_gnt_idx  <= 2'b00;
      r_busy     <= 1'b0;
      r_preempt  <= 1'b0;
      r_hold_cnt <= '0;
      r_last_idx <= 2'b11;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state    <= StOwned;
            r_gnt      <= w_pick_gnt;
            r_gnt_idx  <= w_pick_idx;
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
            r_last_idx <= w_pick_idx;
          end
        end
        StOwned: begin
          if (!w_owner_req) begin
            // Release wins over timeout, so no preempt pulse here.
            if (w_found) begin
              r_gnt      <= w_pick_gnt;
              r_gnt_idx  <= w_pick_idx;
              r_hold_cnt <= '0;
              r_last_idx <= w_pick_idx;
            end else begin
              r_state    <= StIdle;
              r_gnt      <= '0;
              r_gnt_idx  <= 2'b00;
              r_busy     <= 1'b0;
              r_hold_cnt <= '0;
            end
          end else if (w_timeout && w_found) begin
            r_gnt      <= w_pick_gnt;
            r_gnt_idx  <= w_pick_idx;
            r_hold_cnt <= '0;
            r_last_idx <= w_pick_idx;
            r_preempt  <= 1'b1;
          end else if (!w_timeout) begin
            r_hold_cnt <= r_hold_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_gnt_idx;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (MAX_HOLD=4); each scenario task checks
// {gnt, gnt_idx, busy, preempt} against hand-computed values.
module tb_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       busy;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;

  rr_arbiter4 #(
    .MAX_HOLD (4),
    .CNT_W    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req   = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    rst_n = 1'b1;
    req   = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0000_00_00) begin
      n_errors++;
      $display("FAIL reset_async got=%b exp=%b", obs, 8'b0000_00_00);
    end
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0000_00_00) begin
      n_errors++;
      $display("FAIL reset_hold_until_edge got=%b exp=%b", obs, 8'b0000_00_00);
    end
    step();
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0001_00_10) begin
      n_errors++;
      $display("FAIL reset_first_grant got=%b exp=%b", obs, 8'b0001_00_10);
    end
  endtask

  task automatic test_single();
    logic [7:0] obs;
    do_reset();
    req = 4'b0001;
    step();
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0001_00_10) begin
      n_errors++;
      $display("FAIL single_grant got=%b exp=%b", obs, 8'b0001_00_10);
    end
    req = 4'b0000;
    step();
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0000_00_00) begin
      n_errors++;
      $display("FAIL single_release got=%b exp=%b", obs, 8'b0000_00_00);
    end
  endtask

  task automatic test_rr_order();
    logic [7:0] obs;
    logic [7:0] exp;
    logic [3:0] oh;
    logic [1:0] oi;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      oi  = 2'(k % 4);
      oh  = 4'b0001 << oi;
      exp = {oh, oi, 2'b10};
      step();
      obs = {gnt, gnt_idx, busy, preempt};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL rr_order_first k=%0d got=%b exp=%b", k, obs, exp);
      end
      req = 4'b1111;
      step();
      obs = {gnt, gnt_idx, busy, preempt};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL rr_order_second k=%0d got=%b exp=%b", k, obs, exp);
      end
      req = 4'b1111 & ~oh;
    end
  endtask

  task automatic test_preempt();
    logic [7:0] obs;
    logic [7:0] exp;
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 9; c++) begin
      if (c < 4)      exp = 8'b0001_00_10;
      else if (c < 8) exp = {4'b0100, 2'b10, 1'b1, (c == 4)};
      else            exp = 8'b0001_00_11;
      step();
      obs = {gnt, gnt_idx, busy, preempt};
      n_checks++;
      if (obs !== exp) begin
        n_errors++;
        $display("FAIL preempt cycle=%0d got=%b exp=%b", c, obs, exp);
      end
    end
  endtask

  task automatic test_no_contender();
    logic [7:0] obs;
    do_reset();
    req = 4'b1000;
    for (int c = 0; c < 20; c++) begin
      step();
      obs = {gnt, gnt_idx, busy, preempt};
      n_checks++;
      if (obs !== 8'b1000_11_10) begin
        n_errors++;
        $display("FAIL no_contender cycle=%0d got=%b exp=%b", c, obs, 8'b1000_11_10);
      end
    end
    req = 4'b0000;
    step();
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0000_00_00) begin
      n_errors++;
      $display("FAIL no_contender_idle got=%b exp=%b", obs, 8'b0000_00_00);
    end
  endtask

  task automatic test_release_on_timeout();
    logic [7:0] obs;
    do_reset();
    req = 4'b0110;
    for (int c = 0; c < 4; c++) begin
      step();
      obs = {gnt, gnt_idx, busy, preempt};
      n_checks++;
      if (obs !== 8'b0010_01_10) begin
        n_errors++;
        $display("FAIL timeout_hold cycle=%0d got=%b exp=%b", c, obs, 8'b0010_01_10);
      end
    end
    req = 4'b0100;
    step();
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0100_10_10) begin
      n_errors++;
      $display("FAIL release_on_timeout got=%b exp=%b", obs, 8'b0100_10_10);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] obs;
    do_reset();
    req = 4'b0110;
    step();
    req = 4'b0100;
    step();
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0100_10_10) begin
      n_errors++;
      $display("FAIL async_setup got=%b exp=%b", obs, 8'b0100_10_10);
    end
    req = 4'b0110;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0000_00_00) begin
      n_errors++;
      $display("FAIL async_drop got=%b exp=%b", obs, 8'b0000_00_00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0000_00_00) begin
      n_errors++;
      $display("FAIL async_post_release got=%b exp=%b", obs, 8'b0000_00_00);
    end
    step();
    obs = {gnt, gnt_idx, busy, preempt};
    n_checks++;
    if (obs !== 8'b0010_01_10) begin
      n_errors++;
      $display("FAIL async_restart got=%b exp=%b", obs, 8'b0010_01_10);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_preempt();
    test_no_contender();
    test_release_on_timeout();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
